// File: rtl/program_sequencer.sv
// Fetch/issue sequencer: walks pc through the instruction ROM and holds each
// fetched word valid for the decoder for EXEC_CYCLES cycles.
module program_sequencer #(
  parameter int unsigned PC_W        = 4,
  parameter int unsigned INSTR_W     = 11,
  parameter int unsigned EXEC_CYCLES = 2
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic               step,
  input  logic               halt_req,
  input  logic [PC_W-1:0]    start_addr,
  input  logic [PC_W-1:0]    end_addr,
  input  logic [INSTR_W-1:0] rom_data,
  output logic               rom_en,
  output logic [PC_W-1:0]    rom_addr,
  output logic [INSTR_W-1:0] instruction,
  output logic               instr_valid,
  output logic [PC_W-1:0]    pc,
  output logic [1:0]         state,
  output logic               busy,
  output logic               done
);

  localparam int unsigned CNT_W = (EXEC_CYCLES > 1) ? $clog2(EXEC_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(EXEC_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    FETCH = 2'b01,
    LOAD  = 2'b10,
    EXEC  = 2'b11
  } state_t;

  state_t             state_q, state_d;
  logic [PC_W-1:0]    pc_d;
  logic [PC_W-1:0]    end_q, end_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               step_q, step_d;
  logic               halt_q, halt_d;
  logic [INSTR_W-1:0] instr_d;
  logic               done_d;

  assign state    = state_q;
  assign rom_addr = pc;

  // Next-state, datapath and strobe decode
  always_comb begin
    state_d = state_q;
    pc_d    = pc;
    end_d   = end_q;
    cnt_d   = cnt_q;
    step_d  = step_q;
    halt_d  = halt_q;
    instr_d = instruction;
    done_d  = 1'b0;

    // A halt request raised at any point of an instruction stops after it
    if (state_q != IDLE) begin
      halt_d = halt_q | halt_req;
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          pc_d    = start_addr;
          end_d   = end_addr;
          step_d  = 1'b0;
          state_d = FETCH;
        end else if (step) begin
          step_d  = 1'b1;
          state_d = FETCH;
        end
      end
      FETCH: state_d = LOAD;
      LOAD: begin
        instr_d = rom_data;
        cnt_d   = '0;
        state_d = EXEC;
      end
      EXEC: begin
        if (cnt_q == CNT_LAST) begin
          pc_d = pc + PC_W'(1);
          if (pc == end_q && !step_q) begin
            done_d  = 1'b1;
            step_d  = 1'b0;
            halt_d  = 1'b0;
            state_d = IDLE;
          end else if (step_q || halt_q || halt_req) begin
            step_d  = 1'b0;
            halt_d  = 1'b0;
            state_d = IDLE;
          end else begin
            state_d = FETCH;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs; strobes are decoded from the next state
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      pc          <= '0;
      end_q       <= '0;
      cnt_q       <= '0;
      step_q      <= 1'b0;
      halt_q      <= 1'b0;
      instruction <= '0;
      rom_en      <= 1'b0;
      instr_valid <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc          <= pc_d;
      end_q       <= end_d;
      cnt_q       <= cnt_d;
      step_q      <= step_d;
      halt_q      <= halt_d;
      instruction <= instr_d;
      rom_en      <= (state_d == FETCH);
      instr_valid <= (state_d == EXEC);
      busy        <= (state_d != IDLE);
      done        <= done_d;
    end
  end

endmodule

// File: tb/tb_program_sequencer.sv
// Bench for program_sequencer: directed table of runs plus randomized runs
// checked against a transaction-level model of the executed address sequence.
module tb_program_sequencer;

  localparam int unsigned PC_W        = 4;
  localparam int unsigned INSTR_W     = 11;
  localparam int unsigned EXEC_CYCLES = 2;

  logic               clk = 1'b0;
  logic               reset_n = 1'b0;
  logic               start = 1'b0;
  logic               step = 1'b0;
  logic               halt_req = 1'b0;
  logic [PC_W-1:0]    start_addr = '0;
  logic [PC_W-1:0]    end_addr = '0;
  logic [INSTR_W-1:0] rom_data = '0;
  logic               rom_en;
  logic [PC_W-1:0]    rom_addr;
  logic [INSTR_W-1:0] instruction;
  logic               instr_valid;
  logic [PC_W-1:0]    pc;
  logic [1:0]         state;
  logic               busy;
  logic               done;

  program_sequencer #(.PC_W(PC_W), .INSTR_W(INSTR_W), .EXEC_CYCLES(EXEC_CYCLES)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .step(step), .halt_req(halt_req),
    .start_addr(start_addr), .end_addr(end_addr), .rom_data(rom_data),
    .rom_en(rom_en), .rom_addr(rom_addr), .instruction(instruction),
    .instr_valid(instr_valid), .pc(pc), .state(state), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  logic [INSTR_W-1:0] rom [16];
  always @(posedge clk) if (rom_en) rom_data <= rom[rom_addr];

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  // Observations from one run
  logic [INSTR_W-1:0] obs_words[$];
  logic [PC_W-1:0]    obs_addrs[$];
  int                 obs_done_cnt, obs_done_cyc, obs_bad;
  logic               obs_busy_at_done;
  logic [PC_W-1:0]    obs_pc;
  logic [PC_W-1:0]    model_pc;

  // mode: 0 = start, 1 = step, 2 = start+step together
  task automatic run_op(input int mode, input logic [PC_W-1:0] sa, input logic [PC_W-1:0] ea,
                        input int halt_idx, input bit noise);
    int c, fetches, len;
    bit prev_valid, finished;
    obs_words.delete(); obs_addrs.delete();
    obs_done_cnt = 0; obs_done_cyc = 0; obs_bad = 0; obs_busy_at_done = 1'b0;
    @(negedge clk);
    start_addr = sa; end_addr = ea;
    start = (mode != 1); step = (mode != 0);
    @(negedge clk);
    start = 1'b0; step = 1'b0;
    c = 1; fetches = 0; len = 0; prev_valid = 1'b0; finished = 1'b0;
    for (int guard = 0; guard < 300; guard++) begin
      halt_req = 1'b0;
      if (state == 2'b01) begin
        obs_addrs.push_back(rom_addr);
        if (!rom_en) obs_bad++;
        if (fetches == halt_idx) halt_req = 1'b1;
        fetches++;
      end else if (rom_en) obs_bad++;
      if (instr_valid) begin
        if (!prev_valid) begin
          obs_words.push_back(instruction);
          len = 0;
        end else if (instruction !== obs_words[$]) obs_bad++;
        len++;
      end else if (prev_valid && len != EXEC_CYCLES) obs_bad++;
      prev_valid = instr_valid;
      if (noise && (c == 2 || c == 3)) begin
        start = 1'b1; step = 1'b1; start_addr = PC_W'($urandom);
      end else begin
        start = 1'b0; step = 1'b0;
      end
      if (done) begin
        obs_done_cnt++; obs_done_cyc = c; obs_busy_at_done = busy;
      end
      if (state == 2'b00 && c > 1) begin
        finished = 1'b1;
        obs_pc = pc;
        break;
      end
      @(negedge clk);
      c++;
    end
    chk("run_timeout", 32'(!finished), 32'd0);
    halt_req = 1'b0;
    @(negedge clk);
    if (done) obs_done_cnt++;
  endtask

  task automatic check_run(input string tag, input logic [PC_W-1:0] first, input int n,
                           input logic [PC_W-1:0] exp_pc, input bit exp_done);
    logic [PC_W-1:0] a;
    chk({tag, "_count"}, 32'(obs_words.size()), 32'(n));
    chk({tag, "_fetches"}, 32'(obs_addrs.size()), 32'(n));
    for (int i = 0; i < n && i < obs_words.size() && i < obs_addrs.size(); i++) begin
      a = first + PC_W'(i);
      chk({tag, "_addr"}, 32'(obs_addrs[i]), 32'(a));
      chk({tag, "_word"}, 32'(obs_words[i]), 32'(rom[a]));
    end
    chk({tag, "_done_cnt"}, 32'(obs_done_cnt), 32'(exp_done));
    if (exp_done) begin
      chk({tag, "_done_cyc"}, 32'(obs_done_cyc), 32'((2 + EXEC_CYCLES) * n + 1));
      chk({tag, "_busy_at_done"}, 32'(obs_busy_at_done), 32'd0);
    end
    chk({tag, "_pc"}, 32'(obs_pc), 32'(exp_pc));
    chk({tag, "_proto"}, 32'(obs_bad), 32'd0);
  endtask

  typedef struct {
    int              mode;
    logic [PC_W-1:0] sa, ea;
    int              halt_idx;
    bit              noise, idle_halt;
    logic [PC_W-1:0] first;
    int              n;
    logic [PC_W-1:0] exp_pc;
    bit              exp_done;
  } vec_t;

  vec_t tbl[8];

  initial begin
    int mode, hidx, n_full, n;
    logic [PC_W-1:0] sa, ea, first, epc;
    bit nz, ih, ed;

    tbl[0] = '{0, 4'd0,  4'd2,  -1, 1'b0, 1'b0, 4'd0,  3, 4'd3,  1'b1}; // run 0..2
    tbl[1] = '{0, 4'd14, 4'd1,  -1, 1'b0, 1'b0, 4'd14, 4, 4'd2,  1'b1}; // wrap
    tbl[2] = '{0, 4'd0,  4'd5,   1, 1'b0, 1'b0, 4'd0,  2, 4'd2,  1'b0}; // halt
    tbl[3] = '{1, 4'd0,  4'd0,  -1, 1'b0, 1'b0, 4'd2,  1, 4'd3,  1'b0}; // step
    tbl[4] = '{0, 4'd4,  4'd4,  -1, 1'b1, 1'b0, 4'd4,  1, 4'd5,  1'b1}; // busy noise
    tbl[5] = '{2, 4'd7,  4'd9,  -1, 1'b0, 1'b1, 4'd7,  3, 4'd10, 1'b1}; // start+step, idle halt
    tbl[6] = '{0, 4'd5,  4'd6,   0, 1'b0, 1'b0, 4'd5,  1, 4'd6,  1'b0}; // halt first instr
    tbl[7] = '{1, 4'd0,  4'd0,  -1, 1'b0, 1'b0, 4'd6,  1, 4'd7,  1'b0}; // step at end_addr

    for (int i = 0; i < 16; i++) rom[i] = INSTR_W'(i * 37 + 5);
    rom[0] = 11'b001_0010_0101;
    rom[1] = 11'b010_0100_0011;
    rom[2] = 11'b100_0001_1110;

    // Reset held with start asserted
    start = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_rom_en", 32'(rom_en), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_pc", 32'(pc), 32'd0);
    chk("rst_instr", 32'(instruction), 32'd0);
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    start = 1'b0;
    reset_n = 1'b1;
    model_pc = '0;

    for (int i = 0; i < 8; i++) begin
      if (tbl[i].idle_halt) begin
        @(negedge clk); halt_req = 1'b1;
        @(negedge clk); halt_req = 1'b0;
      end
      run_op(tbl[i].mode, tbl[i].sa, tbl[i].ea, tbl[i].halt_idx, tbl[i].noise);
      check_run($sformatf("vec%0d", i), tbl[i].first, tbl[i].n, tbl[i].exp_pc, tbl[i].exp_done);
      model_pc = tbl[i].exp_pc;
    end

    // Reset in the middle of EXEC
    @(negedge clk);
    start_addr = 4'd8; end_addr = 4'd3; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (2) @(negedge clk);
    chk("mid_exec_valid", 32'(instr_valid), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(instr_valid), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_pc", 32'(pc), 32'd0);
    chk("mid_rst_instr", 32'(instruction), 32'd0);
    chk("mid_rst_state", 32'(state), 32'd0);
    @(negedge clk); reset_n = 1'b1;
    model_pc = '0;
    run_op(0, 4'd2, 4'd3, -1, 1'b0);
    check_run("post_rst", 4'd2, 2, 4'd4, 1'b1);
    model_pc = 4'd4;

    // Randomized runs against the transaction model
    for (int r = 0; r < 25; r++) begin
      for (int i = 0; i < 16; i++) rom[i] = INSTR_W'($urandom);
      mode = int'($urandom_range(0, 2));
      sa = PC_W'($urandom); ea = PC_W'($urandom);
      hidx = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 6)) : -1;
      nz = 1'($urandom); ih = 1'($urandom);
      if (mode == 1) begin
        first = model_pc; n = 1; epc = model_pc + PC_W'(1); ed = 1'b0;
      end else begin
        n_full = int'(PC_W'(ea - sa)) + 1;
        n = (hidx >= 0 && hidx < n_full) ? hidx + 1 : n_full;
        first = sa; epc = sa + PC_W'(n); ed = (n == n_full);
      end
      if (ih) begin
        @(negedge clk); halt_req = 1'b1;
        @(negedge clk); halt_req = 1'b0;
      end
      run_op(mode, sa, ea, hidx, nz);
      check_run($sformatf("rnd%0d", r), first, n, epc, ed);
      model_pc = epc;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
